// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: machine width and the commit trace record
// carried from the core model into the trace buffer.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
  } trace_entry_t;

  // x0 is hardwired to zero, so a record that names it carries zero write data.
  function automatic trace_entry_t make_trace_entry(
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] instr,
    input logic [4:0]      reg_addr,
    input logic [XLEN-1:0] reg_data
  );
    trace_entry_t entry;
    entry.pc       = pc;
    entry.instr    = instr;
    entry.reg_addr = reg_addr;
    if (reg_addr == 5'd0) begin
      entry.reg_data = {XLEN{1'b0}};
    end else begin
      entry.reg_data = reg_data;
    end
    return entry;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word fall-through FIFO with pointer-difference occupancy;
// the pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  T            wdata_i,
  output T            rdata_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push_s;
  logic        do_pop_s;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == FULL_CNT);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers; clear overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = {(AW + 1){1'b0}};
      rd_ptr_d = {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= {(AW + 1){1'b0}};
      rd_ptr_q <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit trace buffer between the core model and a trace consumer: masks x0
// write data, counts records lost to overflow and supports a buffer flush.
module commit_trace_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic                       flush_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [XLEN-1:0]            trace_pc_o,
  output logic [XLEN-1:0]            trace_instr_o,
  output logic [4:0]                 trace_reg_addr_o,
  output logic [XLEN-1:0]            trace_reg_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W - 1){1'b0}}, 1'b1};

  trace_entry_t      wr_entry_s;
  trace_entry_t      head_s;
  logic              pop_s;
  logic              drop_s;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign wr_entry_s = make_trace_entry(pc_i, instr_i, reg_addr_i, reg_data_i);
  assign pop_s      = !empty_o && trace_ready_i;
  assign drop_s     = update_i && full_o && !pop_s;

  sync_fifo #(
    .T     (trace_entry_t),
    .DEPTH (DEPTH)
  ) u_store (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (flush_i),
    .push_i  (update_i),
    .pop_i   (pop_s),
    .wdata_i (wr_entry_s),
    .rdata_o (head_s),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  assign trace_valid_o    = !empty_o;
  assign trace_pc_o       = head_s.pc;
  assign trace_instr_o    = head_s.instr;
  assign trace_reg_addr_o = head_s.reg_addr;
  assign trace_reg_data_o = head_s.reg_data;
  assign drop_cnt_o       = drop_cnt_q;

  // Saturating drop counter; a flush empties the buffer but keeps this history.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_q <= {DROP_W{1'b0}};
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
